// File: rtl/uart_char_tx_if.sv
// Character push / status bundle between the core-side producer and uart_char_tx.
// UART_TX_OVF_CNT_EN adds the ovf_cnt status field.
interface uart_char_tx_if #(
    parameter int unsigned FIFO_AW = 4
);
    logic [7:0]       char_in;
    logic             char_valid;
    logic             txd;
    logic             tx_busy;
    logic             fifo_empty;
    logic             fifo_full;
    logic [FIFO_AW:0] fifo_count;
    logic             overflow;
`ifdef UART_TX_OVF_CNT_EN
    logic [15:0]      ovf_cnt;

    modport master (
        output char_in, char_valid,
        input  txd, tx_busy, fifo_empty, fifo_full, fifo_count, overflow, ovf_cnt
    );

    modport slave (
        input  char_in, char_valid,
        output txd, tx_busy, fifo_empty, fifo_full, fifo_count, overflow, ovf_cnt
    );
`else
    modport master (
        output char_in, char_valid,
        input  txd, tx_busy, fifo_empty, fifo_full, fifo_count, overflow
    );

    modport slave (
        input  char_in, char_valid,
        output txd, tx_busy, fifo_empty, fifo_full, fifo_count, overflow
    );
`endif
endinterface

// File: rtl/uart_char_tx.sv
// Buffers core UART characters in a FIFO and serializes them as 8N1 on txd.
// Define UART_TX_OVF_CNT_EN to add a saturating 16-bit dropped-character counter (ovf_cnt).
module uart_char_tx #(
    parameter int unsigned CLK_DIV = 868,
    parameter int unsigned FIFO_AW = 4
) (
    input logic           clk,
    input logic           rst,
    uart_char_tx_if.slave bus
);
    localparam int unsigned     Depth      = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DepthCnt  = (FIFO_AW + 1)'(Depth);
    localparam logic [FIFO_AW:0] CntOne    = (FIFO_AW + 1)'(1);
    localparam logic [15:0]     BaudReload = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [7:0]         mem [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               empty_q, full_q, overflow_q;
    logic               push, pop, drop;

    state_e      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        busy_q;

    // Pops only come from IDLE, so a push at full is accepted when the FSM frees a slot.
    assign pop  = (state_q == StIdle) && !empty_q;
    assign push = bus.char_valid && (!full_q || pop);
    assign drop = bus.char_valid && full_q && !pop;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == DepthCnt);
            overflow_q <= drop;
        end
    end

    // At full the write lands on the slot being read; the read sees the old contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.char_in;
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        unique case (state_q)
            StIdle: begin
                txd_d = 1'b1;
                if (pop) begin
                    shift_d = mem[rd_ptr_q];
                    baud_d  = BaudReload;
                    txd_d   = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_q == '0) begin
                    txd_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    baud_d    = BaudReload;
                    bit_idx_d = '0;
                    state_d   = StData;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            StData: begin
                if (baud_q == '0) begin
                    baud_d = BaudReload;
                    if (bit_idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = StStop;
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            StStop: begin
                if (baud_q == '0) begin
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            busy_q    <= (state_d != StIdle);
        end
    end

`ifdef UART_TX_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign bus.ovf_cnt = ovf_cnt_q;
`endif

    assign bus.txd        = txd_q;
    assign bus.tx_busy    = busy_q;
    assign bus.fifo_empty = empty_q;
    assign bus.fifo_full  = full_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_char_tx.sv
// Directed bench for uart_char_tx with CLK_DIV=4; a line receiver decodes txd into a queue.
module tb_uart_char_tx;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned FIFO_AW = 4;
    localparam int unsigned FramePeriod = (10 * CLK_DIV + 1) * 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_char_tx_if #(.FIFO_AW(FIFO_AW)) bus ();

    uart_char_tx #(
        .CLK_DIV(CLK_DIV),
        .FIFO_AW(FIFO_AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line receiver: samples mid-bit, records byte, stop bit and start time.
    logic [7:0] rx_q[$];
    logic       rx_s[$];
    time        rx_t[$];
    logic [7:0] rx_b;
    logic       rx_stop;
    time        rx_t0;

    always begin
        @(negedge bus.txd);
        rx_t0 = $time;
        repeat (CLK_DIV / 2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (CLK_DIV) @(posedge clk);
            #1;
            rx_b[i] = bus.txd;
        end
        repeat (CLK_DIV) @(posedge clk);
        #1;
        rx_stop = bus.txd;
        rx_q.push_back(rx_b);
        rx_s.push_back(rx_stop);
        rx_t.push_back(rx_t0);
    end

    logic [7:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] c);
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        tick();
        bus.char_valid = 1'b0;
    endtask

    task automatic flush_rx();
        rx_q.delete();
        rx_s.delete();
        rx_t.delete();
        exp_q.delete();
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int i = 0; i < budget && rx_q.size() < n; i++) tick();
        check_eq("rx_count", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic check_rx(input logic check_gap);
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq("rx_byte", {24'h0, rx_q[i]}, {24'h0, exp_q[i]});
            check_eq("rx_stop", {31'h0, rx_s[i]}, 32'h1);
            if (check_gap && i > 0)
                check_eq("frame_gap", 32'(rx_t[i] - rx_t[i-1]), FramePeriod);
        end
    endtask

    task automatic fill_while_busy(input logic [7:0] first, input logic [7:0] base);
        push(first);
        tick();
        for (int i = 0; i < 16; i++) push(base + 8'(i));
        check_eq("full_flag", {31'h0, bus.fifo_full}, 32'h1);
        check_eq("full_count", 32'(bus.fifo_count), 32'd16);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.char_in    = 8'h00;
        bus.char_valid = 1'b0;
        #1 rst = 1'b1;
        repeat (3) tick();
        check_eq("rst_txd", {31'h0, bus.txd}, 32'h1);
        check_eq("rst_busy", {31'h0, bus.tx_busy}, 32'h0);
        check_eq("rst_empty", {31'h0, bus.fifo_empty}, 32'h1);
        check_eq("rst_full", {31'h0, bus.fifo_full}, 32'h0);
        check_eq("rst_count", 32'(bus.fifo_count), 32'h0);
        check_eq("rst_ovf", {31'h0, bus.overflow}, 32'h0);
        rst = 1'b0;

        // Idle line after reset release
        for (int i = 0; i < 100; i++) begin
            tick();
            check_eq("idle_line", {29'h0, bus.txd, bus.tx_busy, bus.fifo_empty}, 32'b101);
        end

        // Single 'A': 0, 1,0,0,0,0,0,1,0, 1
        flush_rx();
        push(8'h41);
        check_eq("a_empty_after_E", {31'h0, bus.fifo_empty}, 32'h0);
        check_eq("a_count_after_E", 32'(bus.fifo_count), 32'h1);
        check_eq("a_txd_after_E", {31'h0, bus.txd}, 32'h1);
        begin
            logic [9:0] frame;
            frame = {1'b1, 8'h41, 1'b0};
            for (int k = 0; k < 40; k++) begin
                tick();
                check_eq("a_txd_wave", {31'h0, bus.txd}, {31'h0, frame[k / 4]});
                check_eq("a_busy", {31'h0, bus.tx_busy}, 32'h1);
            end
        end
        tick();
        check_eq("a_busy_done", {31'h0, bus.tx_busy}, 32'h0);
        check_eq("a_txd_done", {31'h0, bus.txd}, 32'h1);
        wait_rx(1, 50);
        exp_q.push_back(8'h41);
        check_rx(1'b0);

        // Fill to full behind a busy frame, then overflow with 8'hFF
        flush_rx();
        fill_while_busy(8'h7E, 8'h00);
        push(8'hFF);
        check_eq("ovf_pulse", {31'h0, bus.overflow}, 32'h1);
        check_eq("ovf_count_kept", 32'(bus.fifo_count), 32'd16);
        tick();
        check_eq("ovf_pulse_end", {31'h0, bus.overflow}, 32'h0);
        wait_rx(17, 17 * 41 + 60);
        exp_q.push_back(8'h7E);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        check_rx(1'b1);
        repeat (60) tick();
        check_eq("no_ff_sent", 32'(rx_q.size()), 32'd17);
        check_eq("drained_empty", {31'h0, bus.fifo_empty}, 32'h1);

        // Push at full on the pop edge
        flush_rx();
        fill_while_busy(8'h5A, 8'h20);
        for (int i = 0; i < 60 && bus.tx_busy; i++) tick();
        check_eq("idle_seen", {31'h0, bus.tx_busy}, 32'h0);
        push(8'h30);
        check_eq("pp_count", 32'(bus.fifo_count), 32'd16);
        check_eq("pp_full", {31'h0, bus.fifo_full}, 32'h1);
        check_eq("pp_no_ovf", {31'h0, bus.overflow}, 32'h0);
        wait_rx(18, 18 * 41 + 60);
        exp_q.push_back(8'h5A);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h20 + 8'(i));
        exp_q.push_back(8'h30);
        check_rx(1'b1);

        // Reset in the middle of 8'h55 data bit1 with 3 queued
        repeat (60) tick();
        flush_rx();
        push(8'h55);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        repeat (7) tick();
        check_eq("pre_rst_txd", {31'h0, bus.txd}, 32'h0);
        check_eq("pre_rst_count", 32'(bus.fifo_count), 32'd3);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_mid_txd", {31'h0, bus.txd}, 32'h1);
        check_eq("rst_mid_count", 32'(bus.fifo_count), 32'h0);
        check_eq("rst_mid_busy", {31'h0, bus.tx_busy}, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            check_eq("post_rst_idle", {30'h0, bus.txd, bus.tx_busy}, 32'b10);
        end
        flush_rx();
        repeat (10) tick();
        check_eq("post_rst_no_frame", 32'(rx_q.size()), 32'h0);
        push(8'hAA);
        wait_rx(1, 80);
        exp_q.push_back(8'hAA);
        check_rx(1'b0);

        // Five drops while full
        repeat (20) tick();
        fill_while_busy(8'h11, 8'h40);
        for (int i = 0; i < 5; i++) begin
            push(8'hEE);
            check_eq("drop5_pulse", {31'h0, bus.overflow}, 32'h1);
        end
`ifdef UART_TX_OVF_CNT_EN
        check_eq("ovf_cnt5", 32'(bus.ovf_cnt), 32'd5);
`endif
        #2 rst = 1'b1;
        #1;
        check_eq("final_rst_count", 32'(bus.fifo_count), 32'h0);
`ifdef UART_TX_OVF_CNT_EN
        check_eq("ovf_cnt_clr", 32'(bus.ovf_cnt), 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
